// File: rtl/frame_dump_ctrl.sv
// Frame-store-to-UART dump sequencer: a debounced trigger starts a raster readout (x fastest)
// and each word goes out MSB byte first, with an optional sync/size header and checksum trailer.
module frame_dump_ctrl #(
    parameter int         X_MAX         = 40,
    parameter int         Y_MAX         = 30,
    parameter int         X_BITS        = 6,
    parameter int         Y_BITS        = 5,
    parameter int         WORD_BYTES    = 4,
    parameter int         READ_LAT      = 1,
    parameter int         HOLDOFF_BITS  = 13,
    parameter int         DEBOUNCE_BITS = 14,
    parameter logic [7:0] SYNC_BYTE     = 8'hA5,
    parameter bit         SEND_HEADER   = 1'b1,
    parameter bit         SEND_CHECKSUM = 1'b1
) (
    input  logic                    clk,
    input  logic                    areset,
    input  logic                    trigger,
    input  logic                    abort,
    output logic [X_BITS-1:0]       read_x,
    output logic [Y_BITS-1:0]       read_y,
    input  logic [8*WORD_BYTES-1:0] read_q,
    input  logic                    uart_busy,
    output logic                    uart_wr,
    output logic [7:0]              uart_dat,
    output logic                    busy,
    output logic                    done
);
    typedef enum logic [2:0] {IDLE, HDR, FETCH, SEND, CSUM, FIN} state_t;

    localparam int                W         = 8 * WORD_BYTES;
    localparam logic [X_BITS-1:0] X_LAST    = X_BITS'(X_MAX - 1);
    localparam logic [Y_BITS-1:0] Y_LAST    = Y_BITS'(Y_MAX - 1);
    localparam logic [2:0]        BYTE_LAST = 3'(WORD_BYTES - 1);
    localparam logic [1:0]        LAT       = 2'(READ_LAT);
    localparam logic [7:0]        X_HDR     = 8'(X_MAX);
    localparam logic [7:0]        Y_HDR     = 8'(Y_MAX);

    state_t                   state, state_nx;
    logic                     trig_r;
    logic [DEBOUNCE_BITS-1:0] deb_cnt;
    logic [HOLDOFF_BITS-1:0]  hold_cnt;
    logic [W-1:0]             shreg;
    logic [2:0]               byte_idx;
    logic [1:0]               lat_cnt;
    logic [7:0]               csum;

    logic       start, send_ok, last_byte, last_word, fetch_ready, fin_ready;
    logic       emit, hdr_step, load_word, word_done, fin_pulse;
    logic [7:0] emit_byte;

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            trig_r   <= 1'b0;
            deb_cnt  <= '0;
            hold_cnt <= '0;
        end else begin
            trig_r <= trigger;
            if (trig_r)               deb_cnt <= '0;
            else if (deb_cnt != '1)   deb_cnt <= deb_cnt + 1'b1;
            if (uart_busy || uart_wr) hold_cnt <= '0;
            else if (hold_cnt != '1)  hold_cnt <= hold_cnt + 1'b1;
        end
    end

    // NOTE: uart_wr is registered, so it must gate send_ok itself; otherwise the cycle the
    // strobe is visible (before the UART raises busy) would let a second byte through.
    assign start       = trig_r && (deb_cnt == '1) && (state == IDLE) && !abort;
    assign send_ok     = (hold_cnt == '1) && !uart_busy && !uart_wr;
    assign last_byte   = (byte_idx == BYTE_LAST);
    assign last_word   = (read_x == X_LAST) && (read_y == Y_LAST);
    assign fetch_ready = (lat_cnt == LAT);
    assign fin_ready   = !uart_busy && !uart_wr;
    assign busy        = (state != IDLE);

    always_ff @(posedge clk or posedge areset) begin
        if (areset) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = SEND_HEADER ? HDR : FETCH;
            HDR:     if (send_ok && byte_idx == 3'd2) state_nx = FETCH;
            FETCH:   if (fetch_ready) state_nx = SEND;
            SEND:    if (send_ok && last_byte)
                         state_nx = !last_word ? FETCH : (SEND_CHECKSUM ? CSUM : FIN);
            CSUM:    if (send_ok) state_nx = FIN;
            FIN:     if (fin_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        if (abort && state != IDLE) state_nx = IDLE;
    end

    always_comb begin
        emit      = 1'b0;
        emit_byte = 8'h00;
        hdr_step  = 1'b0;
        load_word = 1'b0;
        word_done = 1'b0;
        fin_pulse = 1'b0;
        case (state)
            HDR: if (send_ok) begin
                emit     = 1'b1;
                hdr_step = 1'b1;
                case (byte_idx)
                    3'd0:    emit_byte = SYNC_BYTE;
                    3'd1:    emit_byte = X_HDR;
                    default: emit_byte = Y_HDR;
                endcase
            end
            FETCH: load_word = fetch_ready;
            SEND: if (send_ok) begin
                emit      = 1'b1;
                emit_byte = shreg[W-1 -: 8];
                word_done = last_byte;
            end
            CSUM: if (send_ok) begin
                emit      = 1'b1;
                emit_byte = csum;
            end
            FIN:     fin_pulse = fin_ready;
            default: ;
        endcase
        // Abort wins over every action scheduled for this cycle.
        if (abort) begin
            emit      = 1'b0;
            hdr_step  = 1'b0;
            load_word = 1'b0;
            word_done = 1'b0;
            fin_pulse = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            read_x   <= '0;
            read_y   <= '0;
            uart_wr  <= 1'b0;
            uart_dat <= 8'h00;
            done     <= 1'b0;
            shreg    <= '0;
            byte_idx <= 3'd0;
            lat_cnt  <= 2'd0;
            csum     <= 8'h00;
        end else begin
            uart_wr <= emit;
            done    <= fin_pulse;
            if (emit) uart_dat <= emit_byte;
            lat_cnt <= (state == FETCH && !fetch_ready) ? lat_cnt + 2'd1 : 2'd0;
            if (start) begin
                read_x   <= '0;
                read_y   <= '0;
                byte_idx <= 3'd0;
                csum     <= 8'h00;
            end
            if (hdr_step) byte_idx <= (byte_idx == 3'd2) ? 3'd0 : byte_idx + 3'd1;
            if (load_word) shreg <= read_q;
            if (state == SEND && emit) begin
                csum     <= csum + emit_byte;
                shreg    <= shreg << 8;
                byte_idx <= last_byte ? 3'd0 : byte_idx + 3'd1;
            end
            if (word_done) begin
                if (read_x == X_LAST) begin
                    read_x <= '0;
                    read_y <= (read_y == Y_LAST) ? '0 : read_y + 1'b1;
                end else begin
                    read_x <= read_x + 1'b1;
                end
            end
            if ((abort && state != IDLE) || fin_pulse) begin
                read_x <= '0;
                read_y <= '0;
            end
        end
    end
endmodule

// File: tb/tb_frame_dump_ctrl.sv
// Directed bench for frame_dump_ctrl: a 2x2 geometry for stream, trigger, abort, stall and reset
// cases, a header/checksum-free variant, and a full 40x30 geometry for length and checksum.
module tb_frame_dump_ctrl;
    typedef logic [7:0] bq_t[$];

    logic clk = 1'b0;
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    logic [7:0] exp_full[12] = '{8'hA5, 8'h02, 8'h02, 8'h00, 8'h80, 8'h01,
                                 8'h81, 8'h10, 8'h80, 8'h11, 8'h81, 8'h24};

    task automatic check_stream(input string tag, input bq_t got, input int first, input int n);
        check({tag, "_len"}, got.size(), n);
        for (int i = 0; i < n && i < got.size(); i++)
            check($sformatf("%s_b%0d", tag, i), got[i], exp_full[first+i]);
    endtask

    // ---------------- small geometry, header and checksum on ----------------
    logic        s_rst = 1'b1, s_trig = 1'b0, s_abort = 1'b0, s_force = 1'b0;
    logic [0:0]  s_x, s_y;
    logic [15:0] s_q;
    logic        s_ubusy, s_wr, s_busy, s_done;
    logic [7:0]  s_dat;
    int          s_ucnt = 0;
    bq_t         s_bytes;
    int          s_wcyc[$];
    int          s_done_cnt = 0, s_forced_wr = 0, s_done_busy = 0;
    int          s_last_wr = -100000, s_min_gap = 100000;

    frame_dump_ctrl #(.X_MAX(2), .Y_MAX(2), .X_BITS(1), .Y_BITS(1), .WORD_BYTES(2), .READ_LAT(1),
                      .HOLDOFF_BITS(2), .DEBOUNCE_BITS(2)) u_small (
        .clk(clk), .areset(s_rst), .trigger(s_trig), .abort(s_abort), .read_x(s_x), .read_y(s_y),
        .read_q(s_q), .uart_busy(s_ubusy), .uart_wr(s_wr), .uart_dat(s_dat), .busy(s_busy),
        .done(s_done));

    always @(posedge clk) s_q <= {8'(8'h10 * s_y + s_x), 8'(8'h80 + s_x)};
    always @(posedge clk) if (s_wr) s_ucnt <= 5; else if (s_ucnt > 0) s_ucnt <= s_ucnt - 1;
    assign s_ubusy = (s_ucnt != 0) || s_force;

    always @(negedge clk) begin
        if (s_wr) begin
            s_bytes.push_back(s_dat);
            s_wcyc.push_back(cyc);
            if (s_force) s_forced_wr++;
            if (cyc - s_last_wr < s_min_gap) s_min_gap = cyc - s_last_wr;
            s_last_wr = cyc;
        end
        if (s_done) begin
            s_done_cnt++;
            if (s_busy) s_done_busy++;
        end
    end

    // ---------------- small geometry, no header, no checksum ----------------
    logic        n_rst = 1'b1, n_trig = 1'b0;
    logic [0:0]  n_x, n_y;
    logic [15:0] n_q;
    logic        n_ubusy, n_wr, n_busy, n_done;
    logic [7:0]  n_dat;
    int          n_ucnt = 0;
    bq_t         n_bytes;
    int          n_done_cnt = 0;

    frame_dump_ctrl #(.X_MAX(2), .Y_MAX(2), .X_BITS(1), .Y_BITS(1), .WORD_BYTES(2), .READ_LAT(1),
                      .HOLDOFF_BITS(2), .DEBOUNCE_BITS(2), .SEND_HEADER(1'b0),
                      .SEND_CHECKSUM(1'b0)) u_raw (
        .clk(clk), .areset(n_rst), .trigger(n_trig), .abort(1'b0), .read_x(n_x), .read_y(n_y),
        .read_q(n_q), .uart_busy(n_ubusy), .uart_wr(n_wr), .uart_dat(n_dat), .busy(n_busy),
        .done(n_done));

    always @(posedge clk) n_q <= {8'(8'h10 * n_y + n_x), 8'(8'h80 + n_x)};
    always @(posedge clk) if (n_wr) n_ucnt <= 5; else if (n_ucnt > 0) n_ucnt <= n_ucnt - 1;
    assign n_ubusy = (n_ucnt != 0);

    always @(negedge clk) begin
        if (n_wr) n_bytes.push_back(n_dat);
        if (n_done) n_done_cnt++;
    end

    // ---------------- full 40x30 geometry, 4-byte words ----------------
    logic        b_rst = 1'b1, b_trig = 1'b0;
    logic [5:0]  b_x;
    logic [4:0]  b_y;
    logic [31:0] b_q;
    logic        b_ubusy, b_wr, b_busy, b_done;
    logic [7:0]  b_dat;
    int          b_ucnt = 0;
    bq_t         b_bytes, b_exp;
    int          b_done_cnt = 0, b_addr_bad = 0;
    logic [31:0] b_word;
    logic [7:0]  b_sum;

    frame_dump_ctrl #(.HOLDOFF_BITS(2), .DEBOUNCE_BITS(2)) u_big (
        .clk(clk), .areset(b_rst), .trigger(b_trig), .abort(1'b0), .read_x(b_x), .read_y(b_y),
        .read_q(b_q), .uart_busy(b_ubusy), .uart_wr(b_wr), .uart_dat(b_dat), .busy(b_busy),
        .done(b_done));

    always @(posedge clk) b_q <= {8'(b_y), 8'(b_x), 8'(8'h10 * b_y + b_x), 8'(8'h80 + b_x)};
    always @(posedge clk) if (b_wr) b_ucnt <= 2; else if (b_ucnt > 0) b_ucnt <= b_ucnt - 1;
    assign b_ubusy = (b_ucnt != 0);

    always @(negedge clk) begin
        if (b_wr) b_bytes.push_back(b_dat);
        if (b_done) b_done_cnt++;
        if (b_x >= 6'd40 || b_y >= 5'd30) b_addr_bad++;
    end

    function automatic int done_of(input int sel);
        return (sel == 0) ? s_done_cnt : (sel == 1) ? n_done_cnt : b_done_cnt;
    endfunction

    task automatic wait_done(input string tag, input int sel, input int budget);
        int d0;
        int i;
        d0 = done_of(sel);
        i  = 0;
        while (done_of(sel) == d0 && i < budget) begin
            tick(1);
            i++;
        end
        check({tag, "_done"}, done_of(sel) - d0, 1);
    endtask

    task automatic wait_s_bytes(input string tag, input int n, input int budget);
        int i;
        i = 0;
        while (s_bytes.size() < n && i < budget) begin
            tick(1);
            i++;
        end
        check({tag, "_reach"}, s_bytes.size(), n);
    endtask

    task automatic pulse_s;
        s_trig = 1'b1;
        tick(1);
        s_trig = 1'b0;
    endtask

    int rel;
    int d_save;

    initial begin
        tick(3);
        check("reset_outs", {s_wr, s_dat, s_x, s_y, s_busy, s_done}, '0);
        s_rst = 1'b0;
        n_rst = 1'b0;
        b_rst = 1'b0;
        tick(5);

        // T1: full dump with header and checksum
        pulse_s();
        tick(1);
        check("t1_busy_hi", s_busy, 1'b1);
        wait_done("t1", 0, 500);
        check("t1_busy_lo", s_busy, 1'b0);
        check("t1_done_1cyc", s_done, 1'b0);
        check("t1_addr_home", {s_x, s_y}, 2'b00);
        check_stream("t1", s_bytes, 0, 12);

        // T3: trigger held high gives one dump; short low gap does not re-arm
        s_bytes.delete();
        s_wcyc.delete();
        d_save = s_done_cnt;
        s_trig = 1'b1;
        wait_done("t3", 0, 500);
        tick(60);
        check("t3_one_dump_len", s_bytes.size(), 12);
        check("t3_one_done", s_done_cnt - d_save, 1);
        check("t3_idle_held", s_busy, 1'b0);
        s_trig = 1'b0;
        tick(2);
        s_trig = 1'b1;
        tick(20);
        check("t3_short_low", s_busy, 1'b0);
        s_trig = 1'b0;
        tick(3);
        pulse_s();
        tick(1);
        check("t3_rearm", s_busy, 1'b1);
        tick(30);
        pulse_s();
        wait_done("t3b", 0, 500);
        tick(60);
        check("t3_mid_trig_len", s_bytes.size(), 24);
        check("t3_mid_trig_idle", s_busy, 1'b0);

        // T4: abort after the fifth byte, then a clean restart
        s_bytes.delete();
        s_wcyc.delete();
        d_save = s_done_cnt;
        pulse_s();
        wait_s_bytes("t4", 5, 500);
        s_abort = 1'b1;
        tick(1);
        s_abort = 1'b0;
        check("t4_busy_next", s_busy, 1'b0);
        check("t4_wr_next", s_wr, 1'b0);
        tick(100);
        check("t4_no_more", s_bytes.size(), 5);
        check("t4_no_done", s_done_cnt - d_save, 0);
        s_bytes.delete();
        pulse_s();
        wait_done("t4_re", 0, 500);
        check_stream("t4_re", s_bytes, 0, 12);

        // T5: UART stalls for 100 cycles mid-dump
        s_bytes.delete();
        s_wcyc.delete();
        pulse_s();
        wait_s_bytes("t5", 3, 500);
        s_force = 1'b1;
        tick(100);
        s_force = 1'b0;
        rel = cyc;
        check("t5_hold_len", s_bytes.size(), 3);
        check("t5_no_wr_busy", s_forced_wr, 0);
        wait_done("t5", 0, 500);
        check("t5_gap_ok", (s_wcyc.size() > 3) && (s_wcyc[3] - rel >= 3), 1'b1);
        check_stream("t5", s_bytes, 0, 12);

        // T6: areset mid-SEND, then a fresh dump
        s_bytes.delete();
        s_wcyc.delete();
        pulse_s();
        wait_s_bytes("t6", 6, 500);
        s_rst = 1'b1;
        #1;
        check("t6_reset_outs", {s_wr, s_dat, s_x, s_y, s_busy, s_done}, '0);
        tick(20);
        check("t6_no_wr", s_bytes.size(), 6);
        s_rst = 1'b0;
        tick(5);
        s_bytes.delete();
        pulse_s();
        wait_done("t6_re", 0, 500);
        check_stream("t6_re", s_bytes, 0, 12);
        check("min_gap_ok", s_min_gap >= 4, 1'b1);
        check("done_with_busy", s_done_busy, 0);

        // T2: no header, no checksum
        n_trig = 1'b1;
        tick(1);
        n_trig = 1'b0;
        wait_done("t2", 1, 500);
        check_stream("t2", n_bytes, 3, 8);

        // Full-size geometry: length, content and checksum
        b_exp.delete();
        b_exp.push_back(8'hA5);
        b_exp.push_back(8'h28);
        b_exp.push_back(8'h1E);
        b_sum = 8'h00;
        for (int y = 0; y < 30; y++)
            for (int x = 0; x < 40; x++) begin
                b_word = {8'(y), 8'(x), 8'(16 * y + x), 8'(128 + x)};
                for (int k = 3; k >= 0; k--) begin
                    b_exp.push_back(b_word[8*k +: 8]);
                    b_sum = b_sum + b_word[8*k +: 8];
                end
            end
        b_exp.push_back(b_sum);
        b_trig = 1'b1;
        tick(1);
        b_trig = 1'b0;
        wait_done("big", 2, 60000);
        check("big_len", b_bytes.size(), 4804);
        for (int i = 0; i < b_exp.size() && i < b_bytes.size(); i++)
            check($sformatf("big_b%0d", i), b_bytes[i], b_exp[i]);
        check("big_addr_bounds", b_addr_bad, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
